fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 56 +++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: NOP encoding,
// fetch FSM states, reset PC default and the instruction-queue entry layout.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  // 65-bit queue entry: instruction word, its address, misaligned-fetch flag
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with single-cycle flush; head is visible combinationally.
// Push into a full queue is accepted only when the head is popped in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches under a queue-credit limit,
// buffers in-order responses, and discards responses orphaned by a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_fault
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = CW + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   fault_pc;
  logic          fault_pending;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] q_count;
  logic [SW-1:0] credit_sum;
  logic          q_empty;
  logic          q_push;
  logic          pop_fire;
  logic          fire;
  logic          rsp_keep;
  logic          fault_push;
  fetch_entry_t  q_head;
  fetch_entry_t  q_wdata;

  // A head leaving this cycle frees its slot, which keeps a 1-cycle memory streaming.
  assign pop_fire   = !q_empty && id_ready && !redirect;
  assign credit_sum = {1'b0, outstanding} + {1'b0, q_count} - {{CW{1'b0}}, pop_fire};
  assign imem_req   = rst_n && (state == ST_FETCH) && (credit_sum < SW'(QDEPTH));
  assign imem_addr  = fetch_pc;
  assign fire       = imem_req && imem_gnt;
  assign out_nxt    = outstanding + CW'(fire) - CW'(imem_rvalid);

  assign rsp_keep   = imem_rvalid && (drop_cnt == '0) && !redirect && (state == ST_FETCH);
  assign fault_push = (state == ST_FAULT) && fault_pending && (drop_cnt == '0) && !redirect;
  assign q_push     = rsp_keep || fault_push;
  assign q_wdata    = fault_push ? '{inst: NOP_INST, pc: fault_pc, fault: 1'b1}
                                 : '{inst: imem_rdata, pc: resp_pc, fault: 1'b0};

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (65)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (pop_fire),
    .rdata (q_head),
    .empty (q_empty),
    .count (q_count)
  );

  assign id_valid = !q_empty;
  assign id_inst  = q_empty ? NOP_INST : q_head.inst;
  assign id_pc    = q_empty ? 32'h0 : q_head.pc;
  assign id_fault = !q_empty && q_head.fault;

  // Everything still in flight at a redirect, including a same-cycle grant, becomes a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_FETCH;
      fetch_pc      <= RESET_PC;
      resp_pc       <= RESET_PC;
      fault_pc      <= 32'h0;
      fault_pending <= 1'b0;
      outstanding   <= '0;
      drop_cnt      <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        fault_pc <= redirect_pc;
        drop_cnt <= out_nxt;
        if (is_misaligned(redirect_pc[1:0])) begin
          state         <= ST_FAULT;
          fault_pending <= 1'b1;
        end else begin
          state         <= ST_FETCH;
          fault_pending <= 1'b0;
        end
      end else begin
        if (fire)                             fetch_pc      <= fetch_pc + 32'd4;
        if (imem_rvalid && drop_cnt != '0)    drop_cnt      <= drop_cnt - 1'b1;
        if (rsp_keep)                         resp_pc       <= resp_pc + 32'd4;
        if (fault_push)                       fault_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a queue-based reference model and
// a few hand-derived scenarios pinning latency, redirect, fault and wrap behaviour.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_fault;

  fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_fault    (id_fault)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; bit stale; int gcyc;} req_t;
  typedef struct {logic [31:0] inst; logic [31:0] pc; logic fault;} ent_t;

  req_t        inflight[$];
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fpc;
  bit          m_fault;
  bit          m_fpend;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          p_gnt, p_rsp, p_rdy;
  bit          do_redir = 0;
  logic [31:0] redir_target = 32'h0;

  logic        s_req, s_valid, s_fault;
  logic [31:0] s_addr, s_inst, s_pc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelClear();
    inflight.delete();
    mq.delete();
    m_pc    = RPC;
    m_fpc   = 32'h0;
    m_fault = 0;
    m_fpend = 0;
  endtask

  task automatic applyStimulus();
    imem_rvalid = 1'b0;
    if (inflight.size() > 0)
      if (inflight[0].gcyc < cyc && $urandom_range(99) < p_rsp) imem_rvalid = 1'b1;
    imem_rdata  = $urandom;
    id_ready    = ($urandom_range(99) < p_rdy);
    redirect    = do_redir;
    redirect_pc = redir_target;
    imem_gnt    = 1'b0;
    do_redir    = 0;
  endtask

  task automatic checkOutput();
    ent_t h;
    bit   e_valid, pop, e_req;
    int   occ;
    e_valid = mq.size() > 0;
    if (e_valid) h = mq[0];
    else         h = '{NOP_INST, 32'h0, 1'b0};
    pop   = e_valid && id_ready && !redirect;
    occ   = inflight.size() + mq.size() - int'(pop);
    e_req = !m_fault && (occ < QD);
    s_req = imem_req; s_addr = imem_addr; s_valid = id_valid;
    s_inst = id_inst; s_pc = id_pc; s_fault = id_fault;
    check32("imem_req",  32'(s_req),   32'(e_req));
    check32("imem_addr", s_addr,       m_pc);
    check32("id_valid",  32'(s_valid), 32'(e_valid));
    check32("id_inst",   s_inst,       h.inst);
    check32("id_pc",     s_pc,         h.pc);
    check32("id_fault",  32'(s_fault), 32'(h.fault));
    imem_gnt = e_req && ($urandom_range(99) < p_gnt);
  endtask

  task automatic modelUpdate();
    bit   pop, fpush;
    req_t r;
    pop   = mq.size() > 0 && id_ready && !redirect;
    fpush = m_fault && m_fpend && inflight.size() == 0;
    if (pop) void'(mq.pop_front());
    if (imem_rvalid) begin
      r = inflight.pop_front();
      if (!r.stale && !redirect) mq.push_back('{imem_rdata, r.pc, 1'b0});
    end
    if (imem_gnt) begin
      inflight.push_back('{m_pc, redirect, cyc});
      m_pc += 32'd4;
    end
    if (redirect) begin
      mq.delete();
      foreach (inflight[i]) inflight[i].stale = 1;
      m_pc    = redirect_pc;
      m_fault = (redirect_pc[1:0] != 2'b00);
      m_fpend = m_fault;
      m_fpc   = redirect_pc;
    end else if (fpush) begin
      mq.push_back('{NOP_INST, m_fpc, 1'b1});
      m_fpend = 0;
    end
    cyc++;
  endtask

  task automatic step();
    applyStimulus();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic resetChecks(input string tag);
    check32({tag, " imem_req"},  32'(imem_req), 32'h0);
    check32({tag, " imem_addr"}, imem_addr,     RPC);
    check32({tag, " id_valid"},  32'(id_valid), 32'h0);
    check32({tag, " id_inst"},   id_inst,       NOP_INST);
    check32({tag, " id_pc"},     id_pc,         32'h0);
    check32({tag, " id_fault"},  32'(id_fault), 32'h0);
  endtask

  task automatic doReset(input bit mid);
    if (mid) begin
      #2;
      rst_n = 1'b0;
      #1;
      resetChecks("async_reset");
    end else begin
      rst_n = 1'b0;
    end
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect = 0; redirect_pc = 0; id_ready = 0;
    modelClear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetChecks("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic redirectTo(input logic [31:0] target);
    do_redir     = 1;
    redir_target = target;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addr_log [6];
    logic [31:0] pc_log   [6];
    logic        v_log    [6];
    bit          got;
    int          req_seen;

    doReset(0);

    // Streaming from reset with a 1-cycle memory and an always-ready decoder
    p_gnt = 100; p_rsp = 100; p_rdy = 100;
    for (int k = 0; k < 6; k++) begin
      step();
      addr_log[k] = s_addr; pc_log[k] = s_pc; v_log[k] = s_valid;
    end
    check32("stream addr0", addr_log[0], 32'h0);
    check32("stream addr1", addr_log[1], 32'h4);
    check32("stream addr2", addr_log[2], 32'h8);
    check32("stream latency", 32'(v_log[1]), 32'h0);
    for (int k = 2; k < 5; k++) begin
      check32("stream valid", 32'(v_log[k]), 32'h1);
      check32("stream pc", pc_log[k], 32'((k - 2) * 4));
    end

    // Decoder stall: fetching stops once credit is exhausted, then resumes
    p_rdy = 0;
    repeat (5) step();
    check32("stall req", 32'(s_req), 32'h0);
    check32("stall valid", 32'(s_valid), 32'h1);
    p_rdy = 100;
    repeat (8) step();

    // Redirect with two responses held back: both must be discarded
    p_rsp = 0;
    repeat (4) step();
    check32("held req", 32'(s_req), 32'h0);
    check32("held valid", 32'(s_valid), 32'h0);
    redirectTo(32'h0000_0100);
    p_rsp = 100;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_valid) begin got = 1; break; end
    end
    check32("redirect 0x100 delivered", 32'(got), 32'h1);
    if (got) check32("redirect 0x100 pc", s_pc, 32'h0000_0100);
    repeat (4) step();

    // Misaligned redirect: single fault entry, no fetching
    p_rdy = 0;
    redirectTo(32'h0000_0102);
    got = 0; req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_req) req_seen++;
      if (s_valid) begin got = 1; break; end
    end
    check32("fault delivered", 32'(got), 32'h1);
    check32("fault no req", 32'(req_seen), 32'h0);
    check32("fault pc", s_pc, 32'h0000_0102);
    check32("fault flag", 32'(s_fault), 32'h1);
    check32("fault inst", s_inst, NOP_INST);
    p_rdy = 100;
    repeat (5) step();
    check32("fault idle valid", 32'(s_valid), 32'h0);
    check32("fault idle req", 32'(s_req), 32'h0);

    // Redirect coinciding with a response and a ready decoder
    redirectTo(32'h0000_0200);
    repeat (6) step();
    do_redir = 1; redir_target = 32'h0000_0300;
    step();
    check32("coincident rvalid", 32'(imem_rvalid), 32'h1);
    check32("coincident head valid", 32'(s_valid), 32'h1);
    step();
    check32("coincident flushed", 32'(s_valid), 32'h0);
    repeat (4) step();

    // Fetch PC wraps from the top of the address space
    redirectTo(32'hFFFF_FFFC);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_req) begin got = 1; break; end
    end
    check32("wrap req seen", 32'(got), 32'h1);
    check32("wrap addr top", s_addr, 32'hFFFF_FFFC);
    step();
    check32("wrap addr zero", s_addr, 32'h0000_0000);
    repeat (4) step();

    // Randomized traffic with occasional redirects and one mid-flight reset
    p_gnt = 60; p_rsp = 60; p_rdy = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset(1);
      if ($urandom_range(99) < 3) begin
        do_redir = 1;
        redir_target = {$urandom} & 32'hFFFF_FFFC;
        if ($urandom_range(7) == 0) redir_target = 32'hFFFF_FFF0;
        if ($urandom_range(7) == 0) redir_target[1:0] = 2'($urandom_range(1, 3));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
